sdiv_32_32: RTL

Iterative 32-bit divider for the core's execute stage. It sits next to `smult_32_32` and uses the same operand format and `req`/`rdy` handshake. It returns a quotient and a remainder for signed and unsigned division, with RISC-V DIV/DIVU/REM/REMU semantics. The core selects signed or unsigned division by how it extends the operands to 33 bits.

---
 rtl/sdiv_32_32.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/sdiv_32_32.sv
// Iterative 32-bit signed/unsigned divider (restoring, one quotient bit per cycle).
// Operands arrive 33 bits wide. Bit 32 carries the sign for signed ops and is 0 for
// unsigned ops, so one datapath covers DIV/DIVU/REM/REMU.
//
//   state | meaning
//   IDLE  | wait for req; capture magnitudes and signs, or finish via a fast path
//   CALC  | 32 restoring iterations on the magnitudes
//   FIX   | apply result signs, publish q/r, pulse rdy
//   DONE  | wait for req to drop so a stale req cannot retrigger
module sdiv_32_32 #(
    parameter bit FAST_PATH = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [32:0] ai,
    input  logic [32:0] bi,
    input  logic        req,
    output logic        rdy,
    output logic [31:0] q,
    output logic [31:0] r
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic        nq_q, nq_d;
    logic        nr_q, nr_d;
    logic [31:0] bu_q, bu_d;
    // Partial remainder. It always stays below the divisor, so its 33rd bit
    // would always be zero and is not stored.
    logic [31:0] prem_q, prem_d;
    logic [31:0] quo_q, quo_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic        rdy_q, rdy_d;

    logic [31:0] au_c;
    logic [31:0] bu_c;
    logic [32:0] t_c;

    // Next-state and datapath update; negations are used only at capture and FIX.
    always_comb begin
        au_c    = ai[32] ? (32'd0 - ai[31:0]) : ai[31:0];
        bu_c    = bi[32] ? (32'd0 - bi[31:0]) : bi[31:0];
        t_c     = {prem_q, quo_q[31]} - {1'b0, bu_q};

        state_d = state_q;
        nq_d    = nq_q;
        nr_d    = nr_q;
        bu_d    = bu_q;
        prem_d  = prem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        rdy_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    nq_d = ai[32] ^ bi[32];
                    nr_d = ai[32];
                    bu_d = bu_c;
                    if (bi == 33'd0) begin
                        q_d     = 32'hFFFF_FFFF;
                        r_d     = ai[31:0];
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else if (FAST_PATH && (au_c < bu_c)) begin
                        q_d     = 32'd0;
                        r_d     = ai[31:0];
                        rdy_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        prem_d  = 32'd0;
                        quo_d   = au_c;
                        cnt_d   = 5'd0;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (!t_c[32]) begin
                    prem_d = t_c[31:0];
                    quo_d  = {quo_q[30:0], 1'b1};
                end else begin
                    prem_d = {prem_q[30:0], quo_q[31]};
                    quo_d  = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                q_d     = nq_q ? (32'd0 - quo_q) : quo_q;
                r_d     = nr_q ? (32'd0 - prem_q) : prem_q;
                rdy_d   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                if (!req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            bu_q    <= 32'd0;
            prem_q  <= 32'd0;
            quo_q   <= 32'd0;
            cnt_q   <= 5'd0;
            q_q     <= 32'd0;
            r_q     <= 32'd0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            bu_q    <= bu_d;
            prem_q  <= prem_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            rdy_q   <= rdy_d;
        end
    end

    assign rdy = rdy_q;
    assign q   = q_q;
    assign r   = r_q;

endmodule
